// File: rtl/rv32v_vdiv_sequencer.sv
// Element sequencer for RV32V vdiv/vdivu/vrem/vremu: walks vstart..vl-1, reads operands,
// issues one divide at a time over the divider en/busy handshake and writes each result back.
module rv32v_vdiv_sequencer #(
  parameter  int NELEM = 32,
  localparam int IDX_W = $clog2(NELEM)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [IDX_W:0]   vl,
  input  logic [IDX_W-1:0] vstart,
  input  logic             vm,
  input  logic             is_unsigned,
  input  logic             is_rem,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      rd_vs1,
  input  logic [31:0]      rd_vs2,
  input  logic             rd_mask,
  output logic             div_en,
  output logic [31:0]      div_vs1,
  output logic [31:0]      div_vs2,
  output logic             div_unsigned,
  output logic             div_rem,
  input  logic             div_busy,
  input  logic [31:0]      div_res,
  output logic             wb_en,
  output logic [IDX_W-1:0] wb_idx,
  output logic [31:0]      wb_data
);

  typedef enum logic [2:0] {IDLE, READ, OPND, DIV, WB, DRAIN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   vl_r;
  logic             vm_r;
  logic             div_issue;
  logic [IDX_W:0]   idx_inc;
  logic             last;

  assign busy    = (state != IDLE);
  assign idx_inc = {1'b0, idx} + 1'b1;
  assign last    = (idx_inc >= vl_r);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      idx          <= '0;
      vl_r         <= '0;
      vm_r         <= 1'b0;
      div_issue    <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      rd_idx       <= '0;
      div_en       <= 1'b0;
      div_vs1      <= '0;
      div_vs2      <= '0;
      div_unsigned <= 1'b0;
      div_rem      <= 1'b0;
      wb_en        <= 1'b0;
      wb_idx       <= '0;
      wb_data      <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          vl_r         <= vl;
          vm_r         <= vm;
          div_unsigned <= is_unsigned;
          div_rem      <= is_rem;
          idx          <= vstart;
          if ({1'b0, vstart} >= vl) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state  <= READ;
            rd_en  <= 1'b1;
            rd_idx <= vstart;
          end
        end
        READ: state <= abort ? IDLE : OPND;
        OPND: if (abort) begin
          state <= IDLE;
        end else begin
          div_vs1 <= rd_vs1;
          div_vs2 <= rd_vs2;
          if (!vm_r && !rd_mask) begin
            // masked-off element: no divide, no writeback, straight to the next index
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx    <= idx_inc[IDX_W-1:0];
              rd_idx <= idx_inc[IDX_W-1:0];
              rd_en  <= 1'b1;
              state  <= READ;
            end
          end else begin
            state     <= DIV;
            div_en    <= 1'b1;
            div_issue <= 1'b1;
          end
        end
        DIV: begin
          div_issue <= 1'b0;
          if (abort) begin
            state  <= DRAIN;
            div_en <= 1'b0;
          end else if (!div_issue && !div_busy) begin
            // busy in the issue cycle is stale; only a later low means the result is valid
            wb_data <= div_res;
            div_en  <= 1'b0;
            wb_en   <= 1'b1;
            wb_idx  <= idx;
            state   <= WB;
          end
        end
        WB: if (abort) begin
          state <= IDLE;
        end else if (last) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          idx    <= idx_inc[IDX_W-1:0];
          rd_idx <= idx_inc[IDX_W-1:0];
          rd_en  <= 1'b1;
          state  <= READ;
        end
        DRAIN: if (!div_busy) state <= IDLE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_vdiv_sequencer.sv
// Scoreboard bench for rv32v_vdiv_sequencer: behavioural register file and lane divider,
// expected writebacks queued at issue and checked by an independent monitor.
module tb_rv32v_vdiv_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, vm, is_unsigned, is_rem, abort;
  logic [5:0]  vl;
  logic [4:0]  vstart;
  logic        busy, done, rd_en, div_en, div_unsigned, div_rem, wb_en, div_busy, rd_mask;
  logic [4:0]  rd_idx, wb_idx;
  logic [31:0] rd_vs1, rd_vs2, div_vs1, div_vs2, div_res, wb_data;

  rv32v_vdiv_sequencer dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .vstart(vstart), .vm(vm),
    .is_unsigned(is_unsigned), .is_rem(is_rem), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_vs1(rd_vs1), .rd_vs2(rd_vs2), .rd_mask(rd_mask),
    .div_en(div_en), .div_vs1(div_vs1), .div_vs2(div_vs2), .div_unsigned(div_unsigned),
    .div_rem(div_rem), .div_busy(div_busy), .div_res(div_res),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {int idx; logic [31:0] data;} wb_t;
  wb_t         exp_q[$];
  wb_t         me;
  int          tests = 0, fails = 0;
  int          done_cnt = 0, exp_done = 0, rd_cnt = 0, div_cnt = 0;
  logic [31:0] vs1_m[32], vs2_m[32];
  logic [31:0] mask_m;
  int          lat_fix = 3;
  bit          lat_rand = 1'b0;

  function automatic logic [31:0] ref_div(input logic [31:0] a, b, input logic uns, rem);
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (uns) return rem ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
    return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // register file: data and mask bit appear the cycle after rd_en
  always @(posedge CLK) if (rd_en) begin
    rd_vs1  <= vs1_m[rd_idx];
    rd_vs2  <= vs2_m[rd_idx];
    rd_mask <= mask_m[rd_idx];
  end

  // lane divider: busy in the issue cycle, then for a configurable number of cycles
  logic act;
  int   cnt;
  assign div_busy = (div_en && !act) || (act && cnt != 0);
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      act <= 1'b0; cnt <= 0; div_res <= '0;
    end else if (!act) begin
      if (div_en) begin
        act     <= 1'b1;
        cnt     <= lat_rand ? int'($urandom_range(0, 4)) : lat_fix - 1;
        div_res <= ref_div(div_vs1, div_vs2, div_unsigned, div_rem);
      end
    end else if (cnt != 0) cnt <= cnt - 1;
    else act <= 1'b0;
  end

  always @(negedge CLK) if (nRST) begin
    if (wb_en) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL wb_unexpected: got idx %0d data %0h expected no writeback", wb_idx, wb_data);
      end else begin
        me = exp_q.pop_front();
        check("wb_idx", {27'b0, wb_idx}, me.idx);
        check("wb_data", wb_data, me.data);
      end
    end
    if (done)   done_cnt++;
    if (rd_en)  rd_cnt++;
    if (div_en) div_cnt++;
  end

  task automatic issue(input int vl_i, input int vs_i, input bit vm_i, input bit uns_i,
                       input bit rem_i, input bit push);
    if (push)
      for (int i = vs_i; i < vl_i; i++)
        if (vm_i || mask_m[i]) exp_q.push_back('{idx: i, data: ref_div(vs1_m[i], vs2_m[i], uns_i, rem_i)});
    exp_done++;
    vl = vl_i[5:0]; vstart = vs_i[4:0]; vm = vm_i; is_unsigned = uns_i; is_rem = rem_i;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 3000) begin @(negedge CLK); n++; end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", nm, n);
    end
    check({nm, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic wait_div1(input string nm, input int want_idx);
    int n = 0;
    while (!(div_en && rd_idx == want_idx[4:0]) && n < 500) begin @(negedge CLK); n++; end
    if (!div_en) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got div_en 0 expected div_en 1", nm);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_busy"}, busy, 0);     check({nm, "_done"}, done, 0);
    check({nm, "_rd_en"}, rd_en, 0);   check({nm, "_div_en"}, div_en, 0);
    check({nm, "_wb_en"}, wb_en, 0);   check({nm, "_rd_idx"}, rd_idx, 0);
    check({nm, "_wb_idx"}, wb_idx, 0); check({nm, "_wb_data"}, wb_data, 0);
    check({nm, "_vs1"}, div_vs1, 0);   check({nm, "_vs2"}, div_vs2, 0);
  endtask

  task automatic rand_data();
    mask_m = $urandom;
    for (int i = 0; i < 32; i++) begin
      vs1_m[i] = $urandom;
      case ($urandom_range(0, 7))
        0: vs2_m[i] = 32'h0;
        1: begin vs1_m[i] = 32'h8000_0000; vs2_m[i] = 32'hFFFF_FFFF; end
        2, 3: vs2_m[i] = $urandom_range(1, 50);
        default: vs2_m[i] = $urandom;
      endcase
    end
  endtask

  initial begin
    int r0, d0, n;
    nRST = 1'b0; start = 1'b0; abort = 1'b0; vl = '0; vstart = '0;
    vm = 1'b1; is_unsigned = 1'b0; is_rem = 1'b0;
    rand_data();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check_zero("reset");

    // T1: signed quotient, including divide by zero
    vs1_m[0] = 32'd100; vs1_m[1] = 32'hFFFF_FFF9; vs1_m[2] = 32'd9; vs1_m[3] = 32'd0;
    vs2_m[0] = 32'd7;   vs2_m[1] = 32'd2;         vs2_m[2] = 32'd0; vs2_m[3] = 32'd5;
    exp_q.push_back('{idx: 0, data: 32'd14});
    exp_q.push_back('{idx: 1, data: 32'hFFFF_FFFD});
    exp_q.push_back('{idx: 2, data: 32'hFFFF_FFFF});
    exp_q.push_back('{idx: 3, data: 32'd0});
    issue(4, 0, 1, 0, 0, 0);
    wait_done("t1");
    @(negedge CLK);

    // T2: masked unsigned remainder
    for (int i = 0; i < 4; i++) begin vs1_m[i] = 32'd17; vs2_m[i] = 32'd5; end
    mask_m = 32'b1010;
    exp_q.push_back('{idx: 1, data: 32'd2});
    exp_q.push_back('{idx: 3, data: 32'd2});
    issue(4, 0, 0, 1, 1, 0);
    wait_done("t2");
    @(negedge CLK);

    // T3: empty body, done one cycle after start
    r0 = rd_cnt; d0 = div_cnt;
    issue(5, 5, 1, 0, 0, 1);
    check("t3_done_latency", done, 1);
    wait_done("t3");
    @(negedge CLK);
    check("t3_rd_en_cycles", rd_cnt - r0, 0);
    check("t3_div_en_cycles", div_cnt - d0, 0);

    // T4: abort three cycles into the divide of element 1
    rand_data(); lat_fix = 10;
    issue(4, 0, 1, 0, 0, 1);
    wait_div1("t4", 1);
    repeat (2) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    exp_q.delete(); exp_done--;
    check("t4_div_en_drop", div_en, 0);
    check("t4_busy_drain", busy, 1);
    n = 0;
    while (busy && n < 100) begin @(negedge CLK); n++; end
    check("t4_busy_cleared", busy, 0);
    check("t4_div_busy_at_idle", div_busy, 0);
    repeat (3) @(negedge CLK);

    // T5: start while busy is ignored; back-to-back start right after done
    rand_data(); lat_fix = 2;
    issue(3, 0, 1, 1, 0, 1);
    repeat (2) @(negedge CLK);
    vl = 6'd8; vstart = 5'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("t5a");
    @(negedge CLK);
    check("t5_idle_after_done", busy, 0);
    issue(2, 0, 1, 0, 1, 1);
    wait_done("t5b");
    @(negedge CLK);

    // T6: asynchronous reset during a divide, then a clean instruction
    rand_data(); lat_fix = 10;
    issue(4, 0, 1, 0, 0, 1);
    wait_div1("t6", 0);
    #2 nRST = 1'b0;
    #1 check_zero("t6_async");
    exp_q.delete(); exp_done--;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    rand_data();
    issue(6, 1, 0, 1, 1, 1);
    wait_done("t6_after");
    @(negedge CLK);

    // randomized instructions, random divider latency
    lat_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      rand_data();
      issue($urandom_range(0, 32), $urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      wait_done("rand");
      @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    check("done_count", done_cnt, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
